// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data-memory responder: state encoding,
// default geometry and the address legality check used by both ports.
package data_memory_pkg;
    localparam int XLEN                      = 32;
    localparam int DMEM_DEPTH_WORDS_DEFAULT  = 1024;
    localparam int DMEM_READ_LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    // Word aligned and inside the array; the compare is one bit wider so a
    // full-range depth cannot overflow the limit.
    function automatic logic dmem_addr_legal(input logic [XLEN-1:0] addr,
                                             input int depth_words);
        logic [XLEN:0] limit;
        limit = (XLEN+1)'(depth_words) << 2;
        return (addr[1:0] == 2'b00) && ({1'b0, addr} < limit);
    endfunction
endpackage

// File: rtl/data_memory_if.sv
// CPU data-memory port: load request, store strobe, shared address and the
// responder's data/valid/busy/error returns.
interface data_memory_if;
    import data_memory_pkg::*;

    logic            read_req_i;
    logic            mem_write_i;
    logic [XLEN-1:0] mem_addr_i;
    logic [XLEN-1:0] mem_data_i;
    logic [XLEN-1:0] mem_data_o;
    logic            mem_data_valid_o;
    logic            busy_o;
    logic            error_o;

    modport master (
        output read_req_i, mem_write_i, mem_addr_i, mem_data_i,
        input  mem_data_o, mem_data_valid_o, busy_o, error_o
    );

    modport slave (
        input  read_req_i, mem_write_i, mem_addr_i, mem_data_i,
        output mem_data_o, mem_data_valid_o, busy_o, error_o
    );
endinterface

// File: rtl/data_memory_mem_array.sv
// 1R/1W register array with a registered, read-before-write read port.
// The storage itself is never reset; only the read register is.
module data_memory_mem_array #(
    parameter int W     = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic          rclr_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // rclr_i returns zero for an illegal read instead of aliasing a word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  rdata_o <= '0;
        else if (re_i) rdata_o <= rclr_i ? '0 : mem[raddr_i];
    end
endmodule

// File: rtl/data_memory.sv
// Data-memory responder: fixed-latency loads with a one-cycle valid pulse,
// single-cycle stores, and an error pulse for misaligned/out-of-range access.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS  = DMEM_DEPTH_WORDS_DEFAULT,
    parameter int READ_LATENCY = DMEM_READ_LATENCY_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    data_memory_if.slave  bus
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam bit         LAT1     = (READ_LATENCY == 1);
    localparam logic [3:0] CNT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

    dmem_state_t   state;
    logic [3:0]    cnt;
    logic [AW-1:0] lat_idx;
    logic          lat_ok;
    logic          valid_q, busy_q, err_q;

    logic [AW-1:0] cur_idx;
    logic          cur_ok;
    logic          resp_enter;
    logic [AW-1:0] rd_idx;
    logic          rd_ok;

    assign cur_idx = bus.mem_addr_i[AW+1:2];
    assign cur_ok  = dmem_addr_legal(bus.mem_addr_i, DEPTH_WORDS);

    // With unit latency the read happens on the sampling edge, so the live
    // address is used before it has been latched.
    assign resp_enter = bus.read_req_i &&
                        (((state == IDLE) && LAT1) || ((state == WAIT) && (cnt == 4'd0)));
    assign rd_idx     = (state == IDLE) ? cur_idx : lat_idx;
    assign rd_ok      = (state == IDLE) ? cur_ok  : lat_ok;

    data_memory_mem_array #(.W(XLEN), .DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (bus.mem_write_i && cur_ok),
        .waddr_i (cur_idx),
        .wdata_i (bus.mem_data_i),
        .re_i    (resp_enter),
        .rclr_i  (!rd_ok),
        .raddr_i (rd_idx),
        .rdata_o (bus.mem_data_o)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_idx <= '0;
            lat_ok  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= bus.mem_write_i && !cur_ok;
            case (state)
                IDLE: if (bus.read_req_i) begin
                    lat_idx <= cur_idx;
                    lat_ok  <= cur_ok;
                    busy_q  <= 1'b1;
                    if (LAT1) begin
                        state   <= RESP;
                        valid_q <= 1'b1;
                        if (!cur_ok) err_q <= 1'b1;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: if (!bus.read_req_i) begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end else if (cnt == 4'd0) begin
                    state   <= RESP;
                    valid_q <= 1'b1;
                    if (!lat_ok) err_q <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                // Unconditional return forces an idle gap between loads.
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_data_valid_o = valid_q;
    assign bus.busy_o           = busy_q;
    assign bus.error_o          = err_q;
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench: stimulus pushes expected responses, negedge monitors pop
// and compare whenever a DUT raises valid or error.
module tb_data_memory;
    import data_memory_pkg::*;

    typedef struct {
        logic        valid;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t qa[$];
    exp_t qb[$];

    data_memory_if ifa();
    data_memory_if ifb();

    data_memory #(.DEPTH_WORDS(1024), .READ_LATENCY(2)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifa));
    data_memory #(.DEPTH_WORDS(1024), .READ_LATENCY(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (ifa.mem_data_valid_o || ifa.error_o)) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected: valid=%0b err=%0b data=%h cyc=%0d, required no event",
                         ifa.mem_data_valid_o, ifa.error_o, ifa.mem_data_o, cyc);
            end else begin
                e = qa.pop_front();
                if (ifa.mem_data_valid_o !== e.valid || ifa.error_o !== e.err ||
                    (e.valid && ifa.mem_data_o !== e.data) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL a_resp: got valid=%0b err=%0b data=%h cyc=%0d, required valid=%0b err=%0b data=%h cyc=%0d",
                             ifa.mem_data_valid_o, ifa.error_o, ifa.mem_data_o, cyc,
                             e.valid, e.err, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (ifb.mem_data_valid_o || ifb.error_o)) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: valid=%0b err=%0b data=%h cyc=%0d, required no event",
                         ifb.mem_data_valid_o, ifb.error_o, ifb.mem_data_o, cyc);
            end else begin
                e = qb.pop_front();
                if (ifb.mem_data_valid_o !== e.valid || ifb.error_o !== e.err ||
                    (e.valid && ifb.mem_data_o !== e.data) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL b_resp: got valid=%0b err=%0b data=%h cyc=%0d, required valid=%0b err=%0b data=%h cyc=%0d",
                             ifb.mem_data_valid_o, ifb.error_o, ifb.mem_data_o, cyc,
                             e.valid, e.err, e.data, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store_a(input logic [31:0] addr, input logic [31:0] d, input bit illegal);
        ifa.mem_write_i = 1'b1;
        ifa.mem_addr_i  = addr;
        ifa.mem_data_i  = d;
        if (illegal) qa.push_back('{valid: 1'b0, err: 1'b1, data: 32'h0, cyc: cyc + 1});
        step();
        ifa.mem_write_i = 1'b0;
    endtask

    task automatic store_b(input logic [31:0] addr, input logic [31:0] d);
        ifb.mem_write_i = 1'b1;
        ifb.mem_addr_i  = addr;
        ifb.mem_data_i  = d;
        step();
        ifb.mem_write_i = 1'b0;
    endtask

    // wr_at: 0 none, 1 store in the request cycle, 2 store on the RESP-entry edge
    task automatic load_a(input logic [31:0] addr, input logic [31:0] d, input logic e,
                          input int wr_at, input logic [31:0] wd, input bit chk_busy);
        int nb;
        bit got;
        nb  = 0;
        got = 1'b0;
        ifa.read_req_i  = 1'b1;
        ifa.mem_addr_i  = addr;
        ifa.mem_data_i  = wd;
        ifa.mem_write_i = (wr_at == 1);
        qa.push_back('{valid: 1'b1, err: e, data: d, cyc: cyc + 2});
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (i == 0) ifa.mem_write_i = (wr_at == 2);
            if (i == 1) ifa.mem_write_i = 1'b0;
            if (ifa.busy_o) nb++;
            if (ifa.mem_data_valid_o) got = 1'b1;
        end
        ifa.read_req_i  = 1'b0;
        ifa.mem_write_i = 1'b0;
        if (!got) begin
            errors++;
            $display("FAIL a_load_timeout: addr %h got no valid, required one", addr);
        end
        if (chk_busy) chk("a_busy_cycles", nb, 2);
        step();
    endtask

    task automatic wait_valid_a();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (ifa.mem_data_valid_o) got = 1'b1;
        end
        if (!got) begin
            errors++;
            $display("FAIL a_wait_timeout: got no valid, required one");
        end
    endtask

    task automatic wait_valid_b();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (ifb.mem_data_valid_o) got = 1'b1;
        end
        if (!got) begin
            errors++;
            $display("FAIL b_wait_timeout: got no valid, required one");
        end
    endtask

    initial begin
        ifa.read_req_i = 1'b0; ifa.mem_write_i = 1'b0; ifa.mem_addr_i = '0; ifa.mem_data_i = '0;
        ifb.read_req_i = 1'b0; ifb.mem_write_i = 1'b0; ifb.mem_addr_i = '0; ifb.mem_data_i = '0;
        #1;
        chk("rst_data",  ifa.mem_data_o, 32'h0);
        chk("rst_valid", 32'(ifa.mem_data_valid_o), 32'h0);
        chk("rst_busy",  32'(ifa.busy_o), 32'h0);
        chk("rst_error", 32'(ifa.error_o), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        store_a(32'h10, 32'hDEADBEEF, 1'b0);
        store_a(32'h14, 32'h01234567, 1'b0);
        store_a(32'h00, 32'h11111111, 1'b0);
        store_a(32'h20, 32'hAAAA0000, 1'b0);
        load_a(32'h10, 32'hDEADBEEF, 1'b0, 0, 32'h0, 1'b1);

        // Held request across two loads: pulses at +2 and +5.
        ifa.read_req_i = 1'b1;
        ifa.mem_addr_i = 32'h10;
        qa.push_back('{valid: 1'b1, err: 1'b0, data: 32'hDEADBEEF, cyc: cyc + 2});
        qa.push_back('{valid: 1'b1, err: 1'b0, data: 32'h01234567, cyc: cyc + 5});
        wait_valid_a();
        ifa.mem_addr_i = 32'h14;
        wait_valid_a();
        ifa.read_req_i = 1'b0;
        step();

        load_a(32'h3,    32'h0, 1'b1, 0, 32'h0, 1'b0);
        load_a(32'h1000, 32'h0, 1'b1, 0, 32'h0, 1'b0);
        store_a(32'h1000, 32'hFFFFFFFF, 1'b1);
        load_a(32'h0, 32'h11111111, 1'b0, 0, 32'h0, 1'b0);

        load_a(32'h24, 32'hCAFEF00D, 1'b0, 1, 32'hCAFEF00D, 1'b0);
        load_a(32'h20, 32'hAAAA0000, 1'b0, 2, 32'h55555555, 1'b0);
        load_a(32'h20, 32'h55555555, 1'b0, 0, 32'h0, 1'b0);

        // Latency-4 instance: store landing during WAIT is seen by the read.
        store_b(32'h20, 32'hAAAA0000);
        ifb.read_req_i = 1'b1;
        ifb.mem_addr_i = 32'h20;
        qb.push_back('{valid: 1'b1, err: 1'b0, data: 32'h12345678, cyc: cyc + 4});
        step();
        ifb.mem_write_i = 1'b1;
        ifb.mem_data_i  = 32'h12345678;
        step();
        ifb.mem_write_i = 1'b0;
        wait_valid_b();
        ifb.read_req_i = 1'b0;
        step();

        // Abort in WAIT: drop request in cycle 2.
        ifb.read_req_i = 1'b1;
        step();
        step();
        ifb.read_req_i = 1'b0;
        step();
        chk("b_abort_busy", 32'(ifb.busy_o), 32'h0);
        chk("b_abort_data", ifb.mem_data_o, 32'h12345678);
        repeat (6) step();

        // Asynchronous reset in the middle of a wait.
        ifa.read_req_i = 1'b1;
        ifa.mem_addr_i = 32'h10;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  32'(ifa.busy_o), 32'h0);
        chk("arst_valid", 32'(ifa.mem_data_valid_o), 32'h0);
        chk("arst_data",  ifa.mem_data_o, 32'h0);
        chk("arst_error", 32'(ifa.error_o), 32'h0);
        ifa.read_req_i = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (5) step();
        load_a(32'h10, 32'hDEADBEEF, 1'b0, 0, 32'h0, 1'b0);
        repeat (3) step();

        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
